// File: rtl/ram_writer.sv
// Snapshots a message byte array on a start edge and writes it into RAM at 0..MSG_LENGTH-1,
// optionally reading it back and latching the first mismatching address.
module ram_writer #(
    parameter int MSG_LENGTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter bit VERIFY       = 1'b1,
    parameter int READ_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [MSG_LENGTH-1:0][DATA_WIDTH-1:0] msg_arr,
    output logic [ADDR_WIDTH-1:0]                 address,
    output logic [DATA_WIDTH-1:0]                 wdata,
    output logic                                  wren,
    input  logic [DATA_WIDTH-1:0]                 rdata,
    output logic                                  finished,
    output logic                                  error,
    output logic [ADDR_WIDTH-1:0]                 err_addr,
    output logic [2:0]                            state_tap
);

    // state  | meaning
    // IDLE   | waiting for a start rising edge after reset
    // WRITE  | one byte written per cycle, address = i
    // VERIFY | read addresses issued, compare pipeline filling
    // DRAIN  | READ_LATENCY cycles for outstanding reads to compare
    // DONE   | finished high; a new start edge restarts
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LENGTH - 1);

    state_t                                state;
    logic [ADDR_WIDTH-1:0]                 i;
    logic                                  start_q;
    logic                                  armed;
    logic                                  start_pulse;
    logic [MSG_LENGTH-1:0][DATA_WIDTH-1:0] msg_buf;
    logic [1:0]                            drain_cnt;
    logic [READ_LATENCY-1:0]               pipe_v;
    logic [ADDR_WIDTH-1:0]                 pipe_a [READ_LATENCY];
    logic                                  head_v;
    logic [ADDR_WIDTH-1:0]                 head_a;

    // armed masks the first cycle after reset so a start held high across release is no edge
    assign start_pulse = armed & start & ~start_q;
    assign head_v      = pipe_v[READ_LATENCY-1];
    assign head_a      = pipe_a[READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            i         <= '0;
            start_q   <= 1'b0;
            armed     <= 1'b0;
            msg_buf   <= '0;
            drain_cnt <= '0;
            error     <= 1'b0;
            err_addr  <= '0;
        end else begin
            start_q <= start;
            armed   <= 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_pulse) begin
                        msg_buf  <= msg_arr;
                        i        <= '0;
                        error    <= 1'b0;
                        err_addr <= '0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i == LAST_ADDR) begin
                        i     <= '0;
                        state <= VERIFY ? S_VERIFY : S_DONE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (i == LAST_ADDR) begin
                        i         <= '0;
                        drain_cnt <= 2'(READ_LATENCY - 1);
                        state     <= S_DRAIN;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) state <= S_DONE;
                    else                   drain_cnt <= drain_cnt - 2'd1;
                end
                default: state <= S_IDLE;
            endcase

            if ((state == S_VERIFY || state == S_DRAIN) && head_v && !error
                && (rdata != msg_buf[head_a])) begin
                error    <= 1'b1;
                err_addr <= head_a;
            end
        end
    end

    // Tracks which address each returning read belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            for (int s = 0; s < READ_LATENCY; s++) pipe_a[s] <= '0;
        end else begin
            pipe_v[0] <= (state == S_VERIFY);
            pipe_a[0] <= i;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_a[s] <= pipe_a[s-1];
            end
        end
    end

    always_comb begin
        address = '0;
        wdata   = '0;
        wren    = 1'b0;
        case (state)
            S_WRITE: begin
                address = i;
                wdata   = msg_buf[i];
                wren    = 1'b1;
            end
            S_VERIFY: address = i;
            default: ;
        endcase
    end

    assign finished  = (state == S_DONE);
    assign state_tap = state;

endmodule

// File: doc/ram_writer.md
# ram_writer

Writer counterpart to the key-ROM loader: snapshots a parallel byte array (the decrypted message) on a start edge and writes it byte-by-byte into on-chip RAM at addresses 0..MSG_LENGTH-1. It can optionally run a read-back verify pass, checking RAM contents against the snapshot and flagging the first mismatching address. It sits at the output end of the decryption datapath, between the decrypt core and the result RAM.

## Interface
- MSG_LENGTH, 32: number of bytes written
- ADDR_WIDTH, 5: RAM address width; MSG_LENGTH ≤ 2**ADDR_WIDTH
- DATA_WIDTH, 8: byte width
- VERIFY, 1: 1 runs a read-back verify pass after the write pass; 0 skips it
- READ_LATENCY, 1: RAM read latency in cycles, legal range 1..3
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level input; only its rising edge is acted on
- msg_arr  in  [MSG_LENGTH-1:0][DATA_WIDTH-1:0]  bytes to write
- address  out  ADDR_WIDTH  RAM address
- wdata  out  DATA_WIDTH  RAM write data
- wren  out  1  RAM write enable
- rdata  in  DATA_WIDTH  RAM read data; valid READ_LATENCY cycles after address
- finished  out  1  high in DONE
- error  out  1  sticky verify-mismatch flag
- err_addr  out  ADDR_WIDTH  address of the first mismatch
- state_tap  out  3  current state encoding, for debug

## Operation
- Start detect: start_q holds the previous start sample; start_pulse = start & ~start_q.
- States: IDLE=0, WRITE=1, VERIFY=2, DRAIN=3, DONE=4.
- IDLE/DONE with start_pulse:
  - snapshot msg_arr into buf; i←0.
  - finished←0, error←0, err_addr←0.
  - go to WRITE.
- WRITE:
  - address=i, wdata=buf[i], wren=1, all combinational from state and i.
  - At i==MSG_LENGTH-1: i←0, go to VERIFY (VERIFY=1) or DONE (VERIFY=0).
  - Otherwise i←i+1.
- VERIFY:
  - address=i, wren=0, wdata=0.
  - Push i into a READ_LATENCY-deep valid/address pipeline.
  - At i==MSG_LENGTH-1, go to DRAIN.
- DRAIN: hold for READ_LATENCY cycles while the pipeline empties, then go to DONE.
- Compare (VERIFY and DRAIN states):
  - When the pipeline head is valid with address a, compare rdata with buf[a].
  - On a mismatch with error==0: error←1, err_addr←a.
  - Later mismatches do not change err_addr.
- DONE: finished=1; address, wdata and wren hold 0.
- start_pulse during WRITE, VERIFY or DRAIN is ignored and not queued.
- Counter: i is ADDR_WIDTH bits. The terminal test is equality with MSG_LENGTH-1, never a < compare, so MSG_LENGTH == 2**ADDR_WIDTH works with no wrap.
- buf is loaded only at start. msg_arr changes after that have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, i=0, start_q=0, buf=0, pipeline cleared.
  - address=0, wdata=0, wren=0, finished=0, error=0, err_addr=0.
- Reset mid-operation: wren drops in the same instant; after release the block waits for a fresh rising edge of start.
- start held high through reset release: treated as no edge, because start_q samples it the first cycle after release.
- Latency:
  - start high sampled at edge E0 (start_q=0), so WRITE is entered at E0 and the first wren cycle is E0..E1.
  - wren is high for exactly MSG_LENGTH consecutive cycles.
- VERIFY=0: finished rises at the edge ending the last write cycle. Start edge to finished = MSG_LENGTH+1 edges.
- VERIFY=1: finished rises MSG_LENGTH + MSG_LENGTH + READ_LATENCY cycles after WRITE entry. error/err_addr are final when finished rises.
- Restart from DONE: finished falls at the edge that samples start_pulse.

## Test plan
- VERIFY=0, MSG_LENGTH=32, msg_arr[k]=k^8'hA5, one start pulse:
  - wren high 32 consecutive cycles, address 0..31, wdata 8'hA5..8'hBA (k^8'hA5).
  - finished=1 on the edge after the address-31 write; wren=0 thereafter.
- VERIFY=1, READ_LATENCY=1, model RAM behaving correctly:
  - error=0.
  - finished rises 65 cycles after WRITE entry.
  - address sequences 0..31 twice, wren high only for the first 32 cycles.
- VERIFY=1, READ_LATENCY=2, model RAM corrupts reads at addresses 7 and 20:
  - error=1, err_addr=7 at finished.
  - finished rises 66 cycles after WRITE entry.
- start held high 100 cycles, plus extra start toggles during WRITE:
  - exactly one 32-write pass.
  - Change msg_arr to all 8'h3C, then raise start in DONE: finished drops, 32 writes of 8'h3C, finished rises again, error cleared.
- reset_n low asynchronously while address=10 in WRITE:
  - wren, finished, error and address read 0 before the next edge.
  - After release, no wren until a new start rising edge.
  - start held high across reset release starts nothing.
- msg_arr rewritten to 8'hFF every cycle during WRITE: written data equals the values snapshotted at start; verify reports error=0.
